// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider: DIV (signed quotient) / REMU (unsigned remainder).
// Optional DIV_ZERO_FAST_EN: divide-by-zero and signed overflow skip straight to DONE at accept.
module div_unit #(
   parameter int          XLEN   = 32,
   parameter int          ROB_W  = 4,
   parameter logic [3:0]  OP_DIV = 4'h8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_in,
   input  logic [3:0]       ALU_op,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   input  logic [ROB_W-1:0] ROB_entry,
   input  logic             flush,
   output logic             ready,
   output logic             result_valid,
   output logic [XLEN-1:0]  result,
   output logic [ROB_W-1:0] result_ROB_entry,
   input  logic             result_ack
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   state_t            r_state;
   logic              r_ready;
   logic              r_valid;
   logic [XLEN-1:0]   r_result;
   logic [ROB_W-1:0]  r_tag;
   logic              r_is_div;
   logic              r_neg_q;
   logic              r_special;
   logic [XLEN-1:0]   r_spec_val;
   logic [XLEN-1:0]   r_rem;
   logic [XLEN-1:0]   r_quo;
   logic [XLEN-1:0]   r_dvs;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_is_div;
   logic              w_s1;
   logic              w_s2;
   logic [XLEN-1:0]   w_mag1;
   logic [XLEN-1:0]   w_mag2;
   logic              w_zero;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_spec_val;
   logic [XLEN:0]     w_rem_sh;
   logic [XLEN:0]     w_diff;
   logic              w_sub_ok;
   logic [XLEN-1:0]   w_rem_nx;
   logic [XLEN-1:0]   w_quo_nx;
   logic [XLEN-1:0]   w_fin;

   // Operand conditioning at issue; any op other than DIV behaves as REMU
   assign w_is_div   = (ALU_op == OP_DIV);
   assign w_s1       = w_is_div & rs1[XLEN-1];
   assign w_s2       = w_is_div & rs2[XLEN-1];
   assign w_mag1     = w_s1 ? f_neg(rs1) : rs1;
   assign w_mag2     = w_s2 ? f_neg(rs2) : rs2;
   assign w_zero     = (rs2 == '0);
   assign w_ovf      = w_is_div & (rs1 == INT_MIN) & (rs2 == '1);
   assign w_special  = w_zero | w_ovf;
   assign w_spec_val = w_zero ? (w_is_div ? '1 : rs1) : INT_MIN;

   // One restoring step: {rem,quo} << 1, trial subtract, keep if non-negative
   assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};
   assign w_sub_ok = ~w_diff[XLEN];
   assign w_rem_nx = w_sub_ok ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
   assign w_quo_nx = {r_quo[XLEN-2:0], w_sub_ok};

   assign w_fin = r_special ? r_spec_val :
                  r_is_div  ? (r_neg_q ? f_neg(w_quo_nx) : w_quo_nx) :
                              w_rem_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ready    <= 1'b1;
         r_valid    <= 1'b0;
         r_result   <= '0;
         r_tag      <= '0;
         r_is_div   <= 1'b0;
         r_neg_q    <= 1'b0;
         r_special  <= 1'b0;
         r_spec_val <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvs      <= '0;
         r_cnt      <= '0;
      end else if (flush) begin
         r_state  <= S_IDLE;
         r_ready  <= 1'b1;
         r_valid  <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (valid_in && r_ready) begin
                  r_tag      <= ROB_entry;
                  r_is_div   <= w_is_div;
                  r_neg_q    <= w_s1 ^ w_s2;
                  r_special  <= w_special;
                  r_spec_val <= w_spec_val;
                  r_rem      <= '0;
                  r_quo      <= w_mag1;
                  r_dvs      <= w_mag2;
                  r_cnt      <= CNT_W'(XLEN-1);
                  r_ready    <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
                  if (w_special) begin
                     r_state  <= S_DONE;
                     r_valid  <= 1'b1;
                     r_result <= w_spec_val;
                  end else begin
                     r_state  <= S_BUSY;
                  end
`else
                  r_state    <= S_BUSY;
`endif
               end
            end
            S_BUSY: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               if (r_cnt == '0) begin
                  r_state  <= S_DONE;
                  r_valid  <= 1'b1;
                  r_result <= w_fin;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DONE: begin
               if (result_ack) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign ready            = r_ready;
   assign result_valid     = r_valid;
   assign result           = r_result;
   assign result_ROB_entry = r_tag;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_div_unit;

   localparam int XLEN  = 32;
   localparam int ROB_W = 4;
   localparam logic [3:0] OP_DIV  = 4'h8;
   localparam logic [3:0] OP_REMU = 4'h9;
   localparam logic [3:0] OP_BAD  = 4'h3;
   localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;
`ifdef DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             valid_in;
   logic [3:0]       ALU_op;
   logic [XLEN-1:0]  rs1;
   logic [XLEN-1:0]  rs2;
   logic [ROB_W-1:0] ROB_entry;
   logic             flush;
   logic             ready;
   logic             result_valid;
   logic [XLEN-1:0]  result;
   logic [ROB_W-1:0] result_ROB_entry;
   logic             result_ack;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   div_unit #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_DIV(OP_DIV)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ALU_op(ALU_op),
      .rs1(rs1), .rs2(rs2), .ROB_entry(ROB_entry), .flush(flush),
      .ready(ready), .result_valid(result_valid), .result(result),
      .result_ROB_entry(result_ROB_entry), .result_ack(result_ack)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Architectural result straight from the operation definitions
   function automatic logic [XLEN-1:0] ref_result(input logic is_div,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      logic signed [XLEN-1:0] sa;
      logic signed [XLEN-1:0] sb;
      sa = a;
      sb = b;
      if (is_div) begin
         if (b == 0) return '1;
         if (a == INT_MIN && sb == -1) return INT_MIN;
         return sa / sb;
      end
      if (b == 0) return a;
      return a % b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string name, input logic [3:0] op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [ROB_W-1:0] tag, input int hold);
      logic            is_div;
      logic [XLEN-1:0] exp;
      logic            special;
      int              n;
      int              exp_lat;
      is_div  = (op == OP_DIV);
      exp     = ref_result(is_div, a, b);
      special = (b == 0) || (is_div && a == INT_MIN && b == '1);
      exp_lat = (FAST && special) ? 0 : XLEN;
      check({name, " ready before issue"}, 64'(ready), 64'(1));
      ALU_op = op; rs1 = a; rs2 = b; ROB_entry = tag; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      n = 0;
      while (result_valid !== 1'b1 && n < XLEN + 8) begin
         tick();
         n++;
      end
      check({name, " latency"}, 64'(n), 64'(exp_lat));
      check({name, " result"}, 64'(result), 64'(exp));
      check({name, " tag"}, 64'(result_ROB_entry), 64'(tag));
      for (int i = 0; i < hold; i++) begin
         tick();
         check({name, " hold {ready,valid,tag,result}"},
               64'({ready, result_valid, result_ROB_entry, result}),
               64'({1'b0, 1'b1, tag, exp}));
      end
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check({name, " after ack {valid,ready}"}, 64'({result_valid, ready}), 64'(2'b01));
   endtask

   task automatic watch_no_result(input string name, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         seen = seen | (result_valid === 1'b1);
      end
      check({name, " no result_valid"}, 64'(seen), 64'(0));
   endtask

   initial begin
      logic [3:0]       r_op;
      logic [XLEN-1:0]  r_a;
      logic [XLEN-1:0]  r_b;
      int               sel;

      reset = 1'b1; valid_in = 1'b0; ALU_op = OP_DIV; rs1 = '0; rs2 = '0;
      ROB_entry = '0; flush = 1'b0; result_ack = 1'b0;
      repeat (3) tick();
      check("reset {ready,valid}", 64'({ready, result_valid}), 64'(2'b10));
      check("reset result", 64'(result), 64'(0));
      check("reset tag", 64'(result_ROB_entry), 64'(0));
      reset = 1'b0;
      tick();

      // Reset in the middle of a BUSY op: the op vanishes
      ALU_op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3; ROB_entry = 4'd9; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      check("busy ready low", 64'(ready), 64'(0));
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid-busy reset {ready,valid}", 64'({ready, result_valid}), 64'(2'b10));
      watch_no_result("mid-busy reset", XLEN + 8);

      run_op("div 100/7", OP_DIV, 32'd100, 32'd7, 4'd5, 0);
      run_op("remu 100%7", OP_REMU, 32'd100, 32'd7, 4'd6, 0);
      run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 4'd1, 0);
      run_op("remu fff9%2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 4'd2, 0);
      run_op("div x/0", OP_DIV, 32'd55, 32'd0, 4'd3, 0);
      run_op("remu 1234/0", OP_REMU, 32'h1234, 32'd0, 4'd4, 0);
      run_op("div min/-1", OP_DIV, INT_MIN, 32'hFFFF_FFFF, 4'd7, 0);
      run_op("div hold5", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 4'hA, 5);

      // Flush at BUSY cycle 10 with a new issue in the same cycle
      ALU_op = OP_DIV; rs1 = 32'd5000; rs2 = 32'd13; ROB_entry = 4'd11; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      repeat (9) tick();
      flush = 1'b1; valid_in = 1'b1; ALU_op = OP_REMU; rs1 = 32'd77; rs2 = 32'd5; ROB_entry = 4'd12;
      tick();
      flush = 1'b0; valid_in = 1'b0;
      check("flush busy {ready,valid}", 64'({ready, result_valid}), 64'(2'b10));
      watch_no_result("flush busy", XLEN + 8);
      run_op("post-flush remu", OP_REMU, 32'd77, 32'd5, 4'd12, 1);

      // Flush while DONE, racing an ack: result dropped
      ALU_op = OP_DIV; rs1 = 32'd40; rs2 = 32'd8; ROB_entry = 4'd13; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      repeat (XLEN) tick();
      check("pre-flush done valid", 64'(result_valid), 64'(1));
      flush = 1'b1; result_ack = 1'b1;
      tick();
      flush = 1'b0; result_ack = 1'b0;
      check("flush done {ready,valid}", 64'({ready, result_valid}), 64'(2'b10));

      // Stray ack in IDLE does nothing
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      check("idle ack {ready,valid}", 64'({ready, result_valid}), 64'(2'b10));

      for (int k = 0; k < 24; k++) begin
         sel  = $urandom_range(0, 9);
         r_op = (sel < 5) ? OP_DIV : (sel < 9) ? OP_REMU : OP_BAD;
         r_a  = $urandom;
         case ($urandom_range(0, 5))
            0:       r_b = '0;
            1:       r_b = 32'($urandom_range(1, 20));
            2:       begin r_a = INT_MIN; r_b = '1; end
            3:       r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: r_b = $urandom;
         endcase
         run_op("rnd", r_op, r_a, r_b, 4'($urandom), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
